// File: rtl/turn_controller_if.sv
// Player/datapath bundle for the checkers move sequencer.
// The controller is the slave; the datapath/player side is the master.
interface turn_controller_if;
    logic [5:0]   cursor_loc;
    logic         btn_select;
    logic         btn_cancel;
    logic [27:0]  legal_move;
    logic [191:0] serialized_board;
    logic [5:0]   select_loc;
    logic [2:0]   switch;
    logic         turn_red;
    logic [2:0]   state_o;
    logic         move_done;
    logic         illegal;

    modport master (
        output cursor_loc, btn_select, btn_cancel, legal_move, serialized_board,
        input  select_loc, switch, turn_red, state_o, move_done, illegal
    );

    modport slave (
        input  cursor_loc, btn_select, btn_cancel, legal_move, serialized_board,
        output select_loc, switch, turn_red, state_o, move_done, illegal
    );
endinterface

// File: rtl/turn_controller.sv
// Checkers move sequencer: pick a piece, capture the legal-move slots,
// pick a destination, then clear source and write destination (with promotion).
module turn_controller #(
    parameter int LEGAL_WAIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    turn_controller_if.slave bus
);
    typedef enum logic [2:0] {
        PICK = 3'd0,
        WAIT = 3'd1,
        DEST = 3'd2,
        CLR  = 3'd3,
        PUT  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam int CW = $clog2(LEGAL_WAIT + 1) + 1;

    state_t        state, state_nxt;
    logic [5:0]    src, dst;
    logic [27:0]   moves;
    logic [CW-1:0] count;
    logic [1:0]    piece;      // {red, king} of the picked piece
    logic          turn_red;
    logic          move_done, illegal;

    logic [7:0]    cell_base;
    logic [2:0]    cur_cell;
    logic          pick_ok, any_valid, dest_hit;
    logic [2:0]    put_code;
    logic          take_src, take_dst, capture, illegal_nxt;
    logic [2:0]    sw;
    logic [5:0]    sel;

    assign cell_base = {2'b00, bus.cursor_loc} * 8'd3;
    assign cur_cell  = bus.serialized_board[cell_base +: 3];
    assign pick_ok   = cur_cell[2] && (cur_cell[1] == turn_red);
    assign any_valid = bus.legal_move[27] | bus.legal_move[20]
                     | bus.legal_move[13] | bus.legal_move[6];

    // Selecting the source square itself never counts as a destination.
    always_comb begin
        dest_hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (moves[7*k+6] && (moves[7*k +: 6] == bus.cursor_loc))
                dest_hit = 1'b1;
        end
        if (bus.cursor_loc == src)
            dest_hit = 1'b0;
    end

    // Promotion keys on the destination row: red crowns at y=7, white at y=0.
    always_comb begin
        if (piece[0])
            put_code = piece[1] ? 3'd4 : 3'd5;
        else if (piece[1])
            put_code = (dst[2:0] == 3'd7) ? 3'd4 : 3'd2;
        else
            put_code = (dst[2:0] == 3'd0) ? 3'd5 : 3'd3;
    end

    always_comb begin
        state_nxt   = state;
        take_src    = 1'b0;
        take_dst    = 1'b0;
        capture     = 1'b0;
        illegal_nxt = 1'b0;
        sw          = 3'd0;
        sel         = src;
        case (state)
            PICK: begin
                sel = bus.cursor_loc;
                if (bus.btn_select) begin
                    if (pick_ok) begin
                        take_src  = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        illegal_nxt = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (count == CW'(LEGAL_WAIT)) begin
                    capture = 1'b1;
                    if (any_valid) begin
                        state_nxt = DEST;
                    end else begin
                        illegal_nxt = 1'b1;
                        state_nxt   = PICK;
                    end
                end
            end
            DEST: begin
                if (bus.btn_cancel) begin
                    state_nxt = PICK;
                end else if (bus.btn_select) begin
                    if (dest_hit) begin
                        take_dst  = 1'b1;
                        state_nxt = CLR;
                    end else begin
                        illegal_nxt = 1'b1;
                    end
                end
            end
            CLR: begin
                sw        = 3'd1;
                state_nxt = PUT;
            end
            PUT: begin
                sel       = dst;
                sw        = put_code;
                state_nxt = DONE;
            end
            DONE: begin
                sel       = dst;
                state_nxt = PICK;
            end
            default: state_nxt = PICK;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PICK;
            src       <= '0;
            dst       <= '0;
            moves     <= '0;
            count     <= '0;
            piece     <= '0;
            turn_red  <= 1'b1;
            move_done <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take_src) begin
                src   <= bus.cursor_loc;
                piece <= cur_cell[1:0];
                count <= '0;
            end else if (state == WAIT) begin
                count <= count + 1'b1;
            end
            if (capture)
                moves <= bus.legal_move;
            if (take_dst)
                dst <= bus.cursor_loc;
            illegal   <= illegal_nxt;
            move_done <= (state == PUT);
            if (state == DONE)
                turn_red <= ~turn_red;
        end
    end

    assign bus.select_loc = sel;
    assign bus.switch     = sw;
    assign bus.turn_red   = turn_red;
    assign bus.state_o    = state;
    assign bus.move_done  = move_done;
    assign bus.illegal    = illegal;
endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: the bench plays both the player and
// the datapath (board contents and legal-move vector).
module tb_turn_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    turn_controller_if bus();

    turn_controller #(.LEGAL_WAIT(1)) dut (.clk(clk), .rst(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cell(input int idx, input logic [2:0] v);
        bus.serialized_board[3*idx +: 3] = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cursor_loc = 6'd50;
        bus.btn_select = 1'b0;
        bus.btn_cancel = 1'b0;
        bus.legal_move = '0;
        bus.serialized_board = '0;
        set_cell(50, 3'b110);
        set_cell(9, 3'b100);
        step(); step();
        if (bus.state_o !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", bus.state_o); end n_cmp++;
        if (bus.turn_red !== 1'b1) begin n_err++; $display("FAIL reset_turn got %b want 1", bus.turn_red); end n_cmp++;
        if (bus.switch !== 3'd0) begin n_err++; $display("FAIL reset_switch got %0d want 0", bus.switch); end n_cmp++;
        if ({bus.move_done, bus.illegal} !== 2'b00) begin n_err++; $display("FAIL reset_pulses got %b want 00", {bus.move_done, bus.illegal}); end n_cmp++;
        if (bus.select_loc !== 6'd50) begin n_err++; $display("FAIL reset_sel got %0d want 50", bus.select_loc); end n_cmp++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_illegal_pick();
        bus.cursor_loc = 6'd9;
        bus.btn_select = 1'b1;
        step();
        bus.btn_select = 1'b0;
        if (bus.illegal !== 1'b1) begin n_err++; $display("FAIL t2_illegal got %b want 1", bus.illegal); end n_cmp++;
        if (bus.state_o !== 3'd0) begin n_err++; $display("FAIL t2_state got %0d want 0", bus.state_o); end n_cmp++;
        if (bus.switch !== 3'd0) begin n_err++; $display("FAIL t2_switch got %0d want 0", bus.switch); end n_cmp++;
        step();
        if (bus.illegal !== 1'b0) begin n_err++; $display("FAIL t2_pulse_width got %b want 0", bus.illegal); end n_cmp++;
    endtask

    task automatic test_red_move();
        bus.cursor_loc = 6'd50;
        bus.legal_move = {21'b0, 1'b1, 6'd43};
        bus.btn_select = 1'b1;
        step();
        // select held through the first WAIT cycle must be ignored
        if (bus.state_o !== 3'd1) begin n_err++; $display("FAIL t1_wait1 got %0d want 1", bus.state_o); end n_cmp++;
        if (bus.select_loc !== 6'd50) begin n_err++; $display("FAIL t1_wait_sel got %0d want 50", bus.select_loc); end n_cmp++;
        step();
        bus.btn_select = 1'b0;
        if (bus.state_o !== 3'd1) begin n_err++; $display("FAIL t1_wait2 got %0d want 1", bus.state_o); end n_cmp++;
        step();
        if (bus.state_o !== 3'd2) begin n_err++; $display("FAIL t1_dest got %0d want 2", bus.state_o); end n_cmp++;
        bus.cursor_loc = 6'd43;
        bus.btn_select = 1'b1;
        step();
        bus.btn_select = 1'b0;
        if ({bus.state_o, bus.select_loc, bus.switch} !== {3'd3, 6'd50, 3'd1}) begin n_err++; $display("FAIL t1_clr got st=%0d sel=%0d sw=%0d want 3/50/1", bus.state_o, bus.select_loc, bus.switch); end n_cmp++;
        step();
        if ({bus.state_o, bus.select_loc, bus.switch} !== {3'd4, 6'd43, 3'd2}) begin n_err++; $display("FAIL t1_put got st=%0d sel=%0d sw=%0d want 4/43/2", bus.state_o, bus.select_loc, bus.switch); end n_cmp++;
        set_cell(50, 3'b000);
        set_cell(43, 3'b110);
        step();
        if ({bus.state_o, bus.move_done, bus.switch} !== {3'd5, 1'b1, 3'd0}) begin n_err++; $display("FAIL t1_done got st=%0d md=%b sw=%0d want 5/1/0", bus.state_o, bus.move_done, bus.switch); end n_cmp++;
        step();
        if ({bus.state_o, bus.move_done, bus.turn_red} !== {3'd0, 1'b0, 1'b0}) begin n_err++; $display("FAIL t1_after got st=%0d md=%b turn=%b want 0/0/0", bus.state_o, bus.move_done, bus.turn_red); end n_cmp++;
    endtask

    task automatic test_white_promote();
        bus.cursor_loc = 6'd9;
        bus.legal_move = {21'b0, 1'b1, 6'd0};
        bus.btn_select = 1'b1;
        step();
        bus.btn_select = 1'b0;
        step(); step();
        if (bus.state_o !== 3'd2) begin n_err++; $display("FAIL t3_dest got %0d want 2", bus.state_o); end n_cmp++;
        bus.cursor_loc = 6'd0;
        bus.btn_select = 1'b1;
        step();
        bus.btn_select = 1'b0;
        if ({bus.select_loc, bus.switch} !== {6'd9, 3'd1}) begin n_err++; $display("FAIL t3_clr got sel=%0d sw=%0d want 9/1", bus.select_loc, bus.switch); end n_cmp++;
        step();
        if ({bus.select_loc, bus.switch} !== {6'd0, 3'd5}) begin n_err++; $display("FAIL t3_put got sel=%0d sw=%0d want 0/5", bus.select_loc, bus.switch); end n_cmp++;
        set_cell(9, 3'b000);
        set_cell(0, 3'b101);
        step(); step();
        if (bus.turn_red !== 1'b1) begin n_err++; $display("FAIL t3_turn got %b want 1", bus.turn_red); end n_cmp++;
    endtask

    task automatic test_cancel();
        logic sw_seen;
        sw_seen = 1'b0;
        bus.cursor_loc = 6'd43;
        bus.legal_move = {21'b0, 1'b1, 6'd34};
        bus.btn_select = 1'b1;
        step();
        bus.btn_select = 1'b0;
        sw_seen |= (bus.switch != 3'd0);
        step(); sw_seen |= (bus.switch != 3'd0);
        step(); sw_seen |= (bus.switch != 3'd0);
        bus.cursor_loc = 6'd34;
        bus.btn_select = 1'b1;
        bus.btn_cancel = 1'b1;
        step();
        bus.btn_select = 1'b0;
        bus.btn_cancel = 1'b0;
        sw_seen |= (bus.switch != 3'd0);
        if (bus.state_o !== 3'd0) begin n_err++; $display("FAIL t4_state got %0d want 0", bus.state_o); end n_cmp++;
        if (bus.turn_red !== 1'b1) begin n_err++; $display("FAIL t4_turn got %b want 1", bus.turn_red); end n_cmp++;
        step(); sw_seen |= (bus.switch != 3'd0);
        if (sw_seen !== 1'b0) begin n_err++; $display("FAIL t4_switch got nonzero want 0"); end n_cmp++;
        if (bus.illegal !== 1'b0) begin n_err++; $display("FAIL t4_illegal got %b want 0", bus.illegal); end n_cmp++;
    endtask

    task automatic test_bad_dest();
        bus.cursor_loc = 6'd43;
        // slot2 lists 36 but its valid bit is clear; slot1 lists the source itself
        bus.legal_move = {7'b0, 1'b0, 6'd36, 1'b1, 6'd43, 1'b1, 6'd34};
        bus.btn_select = 1'b1;
        step();
        bus.btn_select = 1'b0;
        step(); step();
        bus.legal_move = '0;
        bus.cursor_loc = 6'd36;
        bus.btn_select = 1'b1;
        step();
        if ({bus.illegal, bus.state_o} !== {1'b1, 3'd2}) begin n_err++; $display("FAIL t5_36 got ill=%b st=%0d want 1/2", bus.illegal, bus.state_o); end n_cmp++;
        bus.cursor_loc = 6'd43;
        step();
        bus.btn_select = 1'b0;
        if ({bus.illegal, bus.state_o} !== {1'b1, 3'd2}) begin n_err++; $display("FAIL t5_src got ill=%b st=%0d want 1/2", bus.illegal, bus.state_o); end n_cmp++;
        step();
        if (bus.illegal !== 1'b0) begin n_err++; $display("FAIL t5_pulse got %b want 0", bus.illegal); end n_cmp++;
        bus.cursor_loc = 6'd34;
        bus.btn_select = 1'b1;
        step();
        bus.btn_select = 1'b0;
        if ({bus.state_o, bus.select_loc, bus.switch} !== {3'd3, 6'd43, 3'd1}) begin n_err++; $display("FAIL t5_clr got st=%0d sel=%0d sw=%0d want 3/43/1", bus.state_o, bus.select_loc, bus.switch); end n_cmp++;
        step();
        if ({bus.select_loc, bus.switch} !== {6'd34, 3'd2}) begin n_err++; $display("FAIL t5_put got sel=%0d sw=%0d want 34/2", bus.select_loc, bus.switch); end n_cmp++;
        set_cell(43, 3'b000);
        set_cell(34, 3'b110);
        step(); step();
        if (bus.turn_red !== 1'b0) begin n_err++; $display("FAIL t5_turn got %b want 0", bus.turn_red); end n_cmp++;
    endtask

    task automatic test_no_moves();
        bus.cursor_loc = 6'd0;
        bus.legal_move = '0;
        bus.btn_select = 1'b1;
        step();
        bus.btn_select = 1'b0;
        step();
        if (bus.state_o !== 3'd1) begin n_err++; $display("FAIL nomv_wait got %0d want 1", bus.state_o); end n_cmp++;
        step();
        if ({bus.state_o, bus.illegal} !== {3'd0, 1'b1}) begin n_err++; $display("FAIL nomv_pick got st=%0d ill=%b want 0/1", bus.state_o, bus.illegal); end n_cmp++;
        step();
        if (bus.illegal !== 1'b0) begin n_err++; $display("FAIL nomv_pulse got %b want 0", bus.illegal); end n_cmp++;
    endtask

    task automatic test_reset_mid_move();
        bus.cursor_loc = 6'd0;
        bus.legal_move = {21'b0, 1'b1, 6'd9};
        bus.btn_select = 1'b1;
        step();
        bus.btn_select = 1'b0;
        step(); step();
        bus.cursor_loc = 6'd9;
        bus.btn_select = 1'b1;
        step();
        bus.btn_select = 1'b0;
        step();
        if ({bus.state_o, bus.switch} !== {3'd4, 3'd5}) begin n_err++; $display("FAIL t6_put got st=%0d sw=%0d want 4/5", bus.state_o, bus.switch); end n_cmp++;
        #2 rst_n = 1'b0;
        #1;
        if (bus.switch !== 3'd0) begin n_err++; $display("FAIL t6_switch got %0d want 0", bus.switch); end n_cmp++;
        if (bus.state_o !== 3'd0) begin n_err++; $display("FAIL t6_state got %0d want 0", bus.state_o); end n_cmp++;
        if (bus.turn_red !== 1'b1) begin n_err++; $display("FAIL t6_turn got %b want 1", bus.turn_red); end n_cmp++;
        step();
        if ({bus.switch, bus.move_done} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL t6_hold got sw=%0d md=%b want 0/0", bus.switch, bus.move_done); end n_cmp++;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_illegal_pick();
        test_red_move();
        test_white_promote();
        test_cancel();
        test_bad_dest();
        test_no_moves();
        test_reset_mid_move();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
